led_pattern_sequencer: RTL and testbench



---
 rtl/led_pattern_sequencer.sv | 105 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - prescaled read-side controller for the left/right LED pattern ROMs
// Steps WAIT -> FETCH -> CAPT once per tick and latches the selected ROM word onto the LEDs.
module led_pattern_sequencer #(
   parameter int unsigned TICK_DIV  = 50000000,
   parameter int unsigned DIV_W     = 26,
   parameter int unsigned ADDR_LAST = 4095
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        run,
   input  logic        dir,
   input  logic        restart,
   output logic        rom_en,
   output logic [11:0] rom_addr,
   output logic        rom_sel,
   input  logic [3:0]  rom_data_l,
   input  logic [3:0]  rom_data_r,
   output logic [3:0]  led,
   output logic        step
);

   typedef enum logic [1:0] {IDLE, WAIT, FETCH, CAPT} state_t;

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [11:0]      ADDR_END   = 12'(ADDR_LAST);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [11:0]      addr_q, addr_d;
   logic [3:0]       led_q, led_d;
   logic             rom_en_q, rom_sel_q, rom_sel_d, step_q;
   logic             pend_q, pend_d;

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      addr_d    = addr_q;
      led_d     = led_q;
      rom_sel_d = rom_sel_q;
      pend_d    = pend_q;
      case (state_q)
         IDLE: begin
            if (restart) addr_d = 12'd0;
            if (run) begin
               state_d = WAIT;
               presc_d = '0;
            end
         end
         WAIT: begin
            if (restart) addr_d = 12'd0;
            if (!run) begin
               state_d = IDLE;
               presc_d = '0;
            end else if (presc_q == PRESC_LAST) begin
               state_d   = FETCH;
               presc_d   = '0;
               rom_sel_d = dir;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         FETCH: begin
            // A restart seen mid-read is deferred so the read finishes on the old address.
            pend_d  = restart;
            state_d = CAPT;
         end
         CAPT: begin
            led_d   = rom_sel_q ? rom_data_r : rom_data_l;
            addr_d  = (restart || pend_q || addr_q == ADDR_END) ? 12'd0 : addr_q + 12'd1;
            pend_d  = 1'b0;
            state_d = run ? WAIT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         addr_q    <= 12'd0;
         led_q     <= 4'h0;
         rom_en_q  <= 1'b0;
         rom_sel_q <= 1'b0;
         step_q    <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         addr_q    <= addr_d;
         led_q     <= led_d;
         rom_en_q  <= (state_d == FETCH);
         rom_sel_q <= rom_sel_d;
         step_q    <= (state_q == CAPT);
         pend_q    <= pend_d;
      end
   end

   assign rom_en   = rom_en_q;
   assign rom_addr = addr_q;
   assign rom_sel  = rom_sel_q;
   assign led      = led_q;
   assign step     = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer
// Phase-count reference model compared every cycle, plus directed literal checks and random stimulus.
module tb_led_pattern_sequencer;

   localparam int TD        = 4;
   localparam int ADDR_LAST = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0, run = 1'b0, dir = 1'b0, restart = 1'b0;
   logic        rom_en, rom_sel, step;
   logic [11:0] rom_addr;
   logic [3:0]  rom_data_l = 4'h0, rom_data_r = 4'h0, led;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   led_pattern_sequencer #(.TICK_DIV(TD), .DIV_W(3), .ADDR_LAST(ADDR_LAST)) dut (
      .clk(clk), .resetn(resetn), .run(run), .dir(dir), .restart(restart),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_sel(rom_sel),
      .rom_data_l(rom_data_l), .rom_data_r(rom_data_r), .led(led), .step(step)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] tbl_l(int unsigned a);
      return 4'(1 << (a % 4));
   endfunction

   function automatic logic [3:0] tbl_r(int unsigned a);
      return 4'(8 >> (a % 4));
   endfunction

   // ROMs: 1-cycle latency, output cleared whenever enable is low
   always @(posedge clk) begin
      rom_data_l <= rom_en ? tbl_l(rom_addr) : 4'h0;
      rom_data_r <= rom_en ? tbl_r(rom_addr) : 4'h0;
   end

   // Model: ph = -1 idle, 0..TD-1 waiting, TD reading, TD+1 capturing
   int          ph = -1;
   int unsigned m_addr = 0;
   logic [3:0]  m_led = 4'h0;
   bit          m_sel = 1'b0, m_step = 1'b0, m_pend = 1'b0;

   always @(posedge clk) begin
      if (!resetn) begin
         ph = -1; m_addr = 0; m_led = 4'h0; m_sel = 1'b0; m_step = 1'b0; m_pend = 1'b0;
      end else begin
         m_step = (ph == TD + 1);
         if (ph == TD + 1) begin
            m_led  = m_sel ? tbl_r(m_addr) : tbl_l(m_addr);
            m_addr = (restart || m_pend) ? 0 : (m_addr + 1) % (ADDR_LAST + 1);
            m_pend = 1'b0;
            ph     = run ? 0 : -1;
         end else if (ph == TD) begin
            m_pend = restart;
            ph     = TD + 1;
         end else begin
            if (restart) m_addr = 0;
            if (ph == -1)  ph = run ? 0 : -1;
            else if (!run) ph = -1;
            else           ph = ph + 1;
            if (ph == TD) m_sel = dir;
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rom_en",   32'(rom_en),   32'(ph == TD));
         chk("rom_addr", 32'(rom_addr), m_addr);
         chk("rom_sel",  32'(rom_sel),  32'(m_sel));
         chk("led",      32'(led),      32'(m_led));
         chk("step",     32'(step),     32'(m_step));
      end
   end

   // Returns the number of edges until rom_en is seen high (bounded)
   task automatic wait_en(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!rom_en && n < 60);
   endtask

   task automatic wait_step(string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step && n < 60);
      chk({name, "_step_seen"}, 32'(step), 32'd1);
   endtask

   int n;
   logic [3:0] exp_seq [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
   logic [3:0] exp_r   [4] = '{4'h8, 4'h4, 4'h2, 4'h1};

   initial begin
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_led", 32'(led), 32'd0);
      chk("reset_addr", 32'(rom_addr), 32'd0);
      chk("reset_en", 32'(rom_en), 32'd0);
      resetn = 1'b1;

      // Left pattern with wrap at ADDR_LAST
      run = 1'b1;
      wait_en(n);
      chk("first_en_latency", 32'(n), 32'd5);
      for (int i = 0; i < 5; i++) begin
         wait_step("left");
         chk("left_led", 32'(led), 32'(exp_seq[i]));
         chk("left_addr", 32'(rom_addr), 32'((i + 1) % 4));
      end

      // Right pattern after a restart in WAIT
      dir = 1'b1;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_wait_addr", 32'(rom_addr), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wait_step("right");
         chk("right_led", 32'(led), 32'(exp_r[i]));
      end

      // dir toggled during FETCH only affects the following step
      wait_en(n);
      chk("rom_sel_fetch", 32'(rom_sel), 32'd1);
      dir = 1'b0;
      wait_step("dirtog0");
      chk("dirtog_old", 32'(led), 32'h8);
      wait_step("dirtog1");
      chk("dirtog_new", 32'(led), 32'h2);

      // Pause during FETCH: capture completes, then hold
      wait_en(n);
      run = 1'b0;
      wait_step("pause");
      chk("pause_led", 32'(led), 32'h4);
      repeat (20) @(negedge clk);
      chk("pause_hold_led", 32'(led), 32'h4);
      chk("pause_hold_addr", 32'(rom_addr), 32'd3);
      run = 1'b1;
      wait_en(n);
      chk("resume_latency", 32'(n), 32'd5);

      // Restart in CAPT at address 2
      wait_step("adv0");
      wait_step("adv1");
      wait_step("adv2");
      wait_en(n);
      chk("pre_restart_addr", 32'(rom_addr), 32'd2);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_capt_addr", 32'(rom_addr), 32'd0);
      chk("restart_capt_led", 32'(led), 32'h4);
      wait_step("after_restart");
      chk("after_restart_led", 32'(led), 32'h1);

      // Reset during CAPT
      wait_en(n);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("rst_capt_led", 32'(led), 32'd0);
      chk("rst_capt_addr", 32'(rom_addr), 32'd0);
      chk("rst_capt_step", 32'(step), 32'd0);
      wait_en(n);
      chk("rst_en_latency", 32'(n), 32'd5);

      // Random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         resetn  = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 19) == 0) run = ~run;
         if ($urandom_range(0, 4) == 0)  dir = ~dir;
         restart = ($urandom_range(0, 24) == 0);
      end
      @(negedge clk);
      resetn = 1'b1;
      restart = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
